systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 167 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Systolic array feeder: buffers {last, act, w} beats in a small FIFO and
// streams each lane's weight MSB-first while holding that beat's activation.
module systolic_feeder #(
  parameter int ACT_WIDTH = 16,
  parameter int N         = 2,
  parameter int W_MAX     = 8,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             precision,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [N*ACT_WIDTH-1:0] in_act,
  input  logic [N*W_MAX-1:0]     in_w,
  output logic [N*ACT_WIDTH-1:0] act_out,
  output logic [N-1:0]           w_out,
  output logic                   active,
  output logic                   busy,
  output logic                   done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(W_MAX + 1);
  localparam int EW = 1 + N*ACT_WIDTH + N*W_MAX;

  typedef enum logic [1:0] {IDLE, SHIFT, STALL} state_t;
  state_t r_state, w_state_next;

  logic [EW-1:0]          r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   w_push, w_pop, w_fifo_empty;
  logic                   w_head_last;
  logic [N*ACT_WIDTH-1:0] w_head_act;
  logic [N*W_MAX-1:0]     w_head_w;

  logic [PW-1:0]          r_prec, r_bit, w_prec_clamp, w_prec_eff;
  logic                   r_last, r_done, w_done_next, w_shift;
  logic [N*ACT_WIDTH-1:0] r_act;

  // in_ready looks only at the registered count, so a pop never frees a slot early.
  assign in_ready     = (r_count < CW'(DEPTH));
  assign w_push       = in_valid && in_ready;
  assign w_fifo_empty = (r_count == '0);
  assign {w_head_last, w_head_act, w_head_w} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_last, in_act, in_w};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_comb begin
    if (precision == 4'd0 || 32'(precision) > W_MAX) begin
      w_prec_clamp = PW'(W_MAX);
    end else begin
      w_prec_clamp = PW'(precision);
    end
  end

  // The first pop of a tile uses the live precision; later pops use the latched one.
  assign w_prec_eff = (r_state == IDLE) ? w_prec_clamp : r_prec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_shift      = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_bit != '0) begin
          w_shift = 1'b1;
        end else if (r_last) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end else if (!w_fifo_empty) begin
          w_pop = 1'b1;
        end else begin
          w_state_next = STALL;
        end
      end
      STALL: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = SHIFT;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_prec <= PW'(W_MAX);
      r_bit  <= '0;
      r_last <= 1'b0;
      r_act  <= '0;
    end else begin
      r_done <= w_done_next;
      if (w_pop) begin
        r_act  <= w_head_act;
        r_last <= w_head_last;
        r_bit  <= w_prec_eff - PW'(1);
        if (r_state == IDLE) r_prec <= w_prec_clamp;
      end else if (w_shift) begin
        r_bit <= r_bit - PW'(1);
      end
    end
  end

  assign act_out = r_act;
  assign active  = (r_state == SHIFT);
  assign busy    = (r_state != IDLE);
  assign done    = r_done;

  // Weight is pre-aligned so bit P-1 sits at the MSB; higher bits fall off the top.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [W_MAX-1:0] r_wsr;
      logic [W_MAX-1:0] w_lane_w;
      assign w_lane_w = w_head_w[gi*W_MAX +: W_MAX];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_wsr <= '0;
        end else if (w_pop) begin
          r_wsr <= w_lane_w << (W_MAX - int'(w_prec_eff));
        end else if (w_shift) begin
          r_wsr <= r_wsr << 1;
        end
      end

      assign w_out[gi] = active & r_wsr[W_MAX-1];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a table of single-beat tiles, hand-written
// multi-cycle sequences, and random tiles checked against a bit-stream model.
module tb_systolic_feeder;
  localparam int N = 2, AW = 16, WM = 8, DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      precision = 4'd4;
  logic            in_valid = 1'b0, in_last = 1'b0;
  logic [N*AW-1:0] in_act = '0;
  logic [N*WM-1:0] in_w = '0;
  logic            in_ready, active, busy, done;
  logic [N*AW-1:0] act_out;
  logic [N-1:0]    w_out;

  always #5 clk = ~clk;

  systolic_feeder #(.ACT_WIDTH(AW), .N(N), .W_MAX(WM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .precision(precision),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_act(in_act), .in_w(in_w),
    .act_out(act_out), .w_out(w_out), .active(active), .busy(busy), .done(done)
  );

  typedef struct {
    logic [N*AW-1:0] act;
    logic [N-1:0]    bits;
  } cyc_t;

  typedef struct {
    logic [3:0]      prec;
    logic [N*AW-1:0] act;
    logic [N*WM-1:0] w;
    int              exp_p;
    logic [7:0]      s0;
    logic [7:0]      s1;
  } vec_t;

  cyc_t exp_q[$];
  cyc_t mon_c;
  int   vectors = 0, miscompares = 0;
  int   done_seen = 0, done_exp = 0;
  int   run_len = 0, last_run = 0, stall_len = 0, last_stall = 0;
  logic prev_done = 1'b0;
  bit   new_tile = 1'b1;
  int   tile_p = WM;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic int clamp_p(input logic [3:0] p);
    return (p == 4'd0 || int'(p) > WM) ? WM : int'(p);
  endfunction

  // Expected active cycles: P per beat, weight bits P-1 down to 0, activation held.
  task automatic model_push(input logic last, input logic [N*AW-1:0] act, input logic [N*WM-1:0] w);
    cyc_t c;
    if (new_tile) tile_p = clamp_p(precision);
    new_tile = last;
    for (int k = tile_p - 1; k >= 0; k--) begin
      c.act = act;
      for (int i = 0; i < N; i++) c.bits[i] = w[i*WM + k];
      exp_q.push_back(c);
    end
    if (last) done_exp++;
    $display("push act=%h w=%h last=%0d P=%0d", act, w, last, tile_p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic last, input logic [N*AW-1:0] act, input logic [N*WM-1:0] w);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_last = last; in_act = act; in_w = w;
    for (int t = 0; t < 100 && !acc; t++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("push_accept", acc, 1);
    if (acc) model_push(last, act, w);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_seen != done_exp && t < 300) begin
      tick();
      t++;
    end
    chk(name, done_seen, done_exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (active) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_active", active, 0);
        end else begin
          mon_c = exp_q.pop_front();
          chk("act_out", act_out, mon_c.act);
          chk("w_out", w_out, mon_c.bits);
        end
        run_len++;
      end else begin
        chk("w_out_inactive", w_out, 0);
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
      if (busy && !active) begin
        stall_len++;
      end else begin
        if (stall_len > 0) last_stall = stall_len;
        stall_len = 0;
      end
      if (done) begin
        done_seen++;
        chk("done_queue_empty", exp_q.size(), 0);
        chk("done_single", prev_done, 0);
      end
      prev_done = done;
    end else begin
      run_len   = 0;
      stall_len = 0;
      prev_done = 1'b0;
    end
  end

  initial begin
    vec_t tbl[7];
    int   t, nb;
    tbl[0] = '{4'd4,  32'h4000_3C00, 16'h0305, 4, 8'h05, 8'h03};
    tbl[1] = '{4'd0,  32'h1234_ABCD, 16'hA53C, 8, 8'h3C, 8'hA5};
    tbl[2] = '{4'd12, 32'h5555_AAAA, 16'h817E, 8, 8'h7E, 8'h81};
    tbl[3] = '{4'd3,  32'h0001_FFFF, 16'hFD12, 3, 8'h02, 8'h05};
    tbl[4] = '{4'd1,  32'hBEEF_CAFE, 16'h01FE, 1, 8'h00, 8'h01};
    tbl[5] = '{4'd8,  32'h7C00_8000, 16'h8001, 8, 8'h01, 8'h80};
    tbl[6] = '{4'd9,  32'h3800_3400, 16'hC35A, 8, 8'h5A, 8'hC3};

    #2;
    chk("rst_act_out", act_out, 0);
    chk("rst_w_out", w_out, 0);
    chk("rst_active", active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 1);
    #21 rst_n = 1'b1;
    tick();

    // Single-beat tiles: 2-cycle latency, P active cycles, then a done pulse.
    for (int v = 0; v < 7; v++) begin
      precision = tbl[v].prec;
      push_beat(1'b1, tbl[v].act, tbl[v].w);
      chk("tbl_latency", active, 0);
      tick();
      for (int k = 0; k < tbl[v].exp_p; k++) begin
        chk("tbl_active", active, 1);
        chk("tbl_act", act_out, tbl[v].act);
        chk("tbl_w0", w_out[0], tbl[v].s0[tbl[v].exp_p-1-k]);
        chk("tbl_w1", w_out[1], tbl[v].s1[tbl[v].exp_p-1-k]);
        tick();
      end
      chk("tbl_end_active", active, 0);
      chk("tbl_done", done, 1);
      tick();
      chk("tbl_done_low", done, 0);
    end

    // Three beats back to back: one unbroken run of 12 active cycles.
    precision = 4'd4;
    push_beat(1'b0, 32'h0101_0202, 16'h0A05);
    push_beat(1'b0, 32'h0303_0404, 16'h0C03);
    push_beat(1'b1, 32'h0505_0606, 16'h0709);
    wait_done("b2b_done");
    chk("b2b_run", last_run, 12);

    // Second beat arrives late: three STALL cycles in between.
    push_beat(1'b0, 32'h1111_2222, 16'h0A05);
    t = 0;
    while (!(busy && !active) && t < 50) begin
      tick();
      t++;
    end
    chk("stall_entered", busy && !active, 1);
    chk("stall_w_zero", w_out, 0);
    tick();
    push_beat(1'b1, 32'h3333_4444, 16'h0F09);
    wait_done("stall_done");
    chk("stall_len", last_stall, 3);

    // Overfill while the first beat is shifting: fifth offer is dropped.
    precision = 4'd8;
    push_beat(1'b0, 32'h0A0A_0B0B, 16'h1122);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      in_valid = 1'b1;
      in_last  = (k >= DEPTH);
      in_act   = {16'(k), 16'(k*3)};
      in_w     = {8'(k*17), 8'(k*29 + 1)};
      chk("ovf_ready", in_ready, (k <= DEPTH));
      if (k <= DEPTH) model_push(in_last, in_act, in_w);
      tick();
    end
    in_valid = 1'b0;
    wait_done("ovf_done");
    repeat (12) tick();

    // Precision change inside a tile only affects the next tile.
    precision = 4'd3;
    push_beat(1'b0, 32'h5A5A_A5A5, 16'hF00F);
    tick();
    precision = 4'd6;
    push_beat(1'b1, 32'h6B6B_B6B6, 16'h3CC3);
    wait_done("midprec_done");
    push_beat(1'b1, 32'h7777_8888, 16'h2D96);
    wait_done("prec6_done");
    chk("prec6_run", last_run, 6);

    // Reset in the middle of a beat: outputs clear at once, tile discarded.
    precision = 4'd4;
    push_beat(1'b1, 32'h9999_1111, 16'h0B0D);
    tick();
    tick();
    chk("pre_rst_active", active, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    new_tile = 1'b1;
    done_exp = done_seen;
    #1;
    chk("midrst_act_out", act_out, 0);
    chk("midrst_w_out", w_out, 0);
    chk("midrst_active", active, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (2) tick();
    #3 rst_n = 1'b1;
    repeat (10) tick();
    chk("no_done_after_rst", done_seen, done_exp);
    chk("idle_after_rst", busy, 0);
    push_beat(1'b1, 32'h2468_1357, 16'h0906);
    wait_done("fresh_tile_done");

    // Random tiles with random gaps between beats.
    for (int tl = 0; tl < 10; tl++) begin
      precision = 4'($urandom_range(0, 15));
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        push_beat(b == nb - 1, $urandom, 16'($urandom));
        repeat ($urandom_range(0, 10)) tick();
      end
      wait_done("rand_done");
      chk("rand_drained", exp_q.size(), 0);
    end
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
